// File: rtl/mem_access_controller_if.sv
// Memory-side bus of mem_access_controller: read/write strobes, address, memory handshake.
// The data bus is a plain inout on the controller so its tristate resolves on one top-level net.
interface mem_access_controller_if #(
  parameter int WORD_SIZE = 16
) ();
  logic                 readM;
  logic                 writeM;
  logic [WORD_SIZE-1:0] address;
  logic                 inputReady;
  logic                 ackOutput;

  modport master (output readM, writeM, address, input  inputReady, ackOutput);
  modport slave  (input  readM, writeM, address, output inputReady, ackOutput);
endinterface

// File: rtl/mem_access_controller.sv
// Single-transaction memory sequencer for the CPU: fetch/data arbitration (data wins),
// four-phase strobe handshake, one-cycle ready pulses. Define MEM_TIMEOUT_EN for the access timeout.
module mem_access_controller #(
  parameter int WORD_SIZE      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    if_req,
  input  logic [WORD_SIZE-1:0]    if_addr,
  output logic                    if_ready,
  output logic [WORD_SIZE-1:0]    if_data,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [WORD_SIZE-1:0]    d_addr,
  input  logic [WORD_SIZE-1:0]    d_wdata,
  output logic                    d_ready,
  output logic [WORD_SIZE-1:0]    d_rdata,
  mem_access_controller_if.master mem,
  inout  wire  [WORD_SIZE-1:0]    data,
  output logic                    busy,
  output logic                    err
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RECOVER} state_t;

  state_t               state_q, state_d;
  logic                 readm_q, readm_d;
  logic                 writem_q, writem_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic                 fetch_q, fetch_d;
  logic                 if_ready_q, if_ready_d;
  logic                 d_ready_q, d_ready_d;
  logic                 err_q, err_d;
  logic [WORD_SIZE-1:0] if_data_q, if_data_d;
  logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
  logic                 busy_q;
  logic                 expire;

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Counts strobe cycles; held at zero outside READ/WRITE so every access starts fresh.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                               tmo_cnt <= '0;
    else if (state_q == READ || state_q == WRITE) tmo_cnt <= tmo_cnt + TW'(1);
    else                                        tmo_cnt <= '0;
  end

  assign expire = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    readm_d    = 1'b0;
    writem_d   = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    fetch_d    = fetch_q;
    if_ready_d = 1'b0;
    d_ready_d  = 1'b0;
    err_d      = 1'b0;
    if_data_d  = if_data_q;
    d_rdata_d  = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (d_req) begin
          addr_d  = d_addr;
          wdata_d = d_wdata;
          fetch_d = 1'b0;
          if (d_we) begin
            state_d  = WRITE;
            writem_d = 1'b1;
          end else begin
            state_d = READ;
            readm_d = 1'b1;
          end
        end else if (if_req) begin
          addr_d  = if_addr;
          fetch_d = 1'b1;
          state_d = READ;
          readm_d = 1'b1;
        end
      end
      READ: begin
        // A response on the expiry edge is a normal completion.
        if (mem.inputReady || expire) begin
          state_d = RECOVER;
          err_d   = !mem.inputReady;
          if (fetch_q) begin
            if_ready_d = 1'b1;
            if_data_d  = mem.inputReady ? data : '1;
          end else begin
            d_ready_d = 1'b1;
            d_rdata_d = mem.inputReady ? data : '1;
          end
        end else begin
          readm_d = 1'b1;
        end
      end
      WRITE: begin
        if (mem.ackOutput || expire) begin
          state_d   = RECOVER;
          d_ready_d = 1'b1;
          err_d     = !mem.ackOutput;
        end else begin
          writem_d = 1'b1;
        end
      end
      RECOVER: begin
        // Wait for memory to finish its side of the four-phase handshake.
        if (!mem.inputReady && !mem.ackOutput) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      readm_q    <= 1'b0;
      writem_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      fetch_q    <= 1'b0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      err_q      <= 1'b0;
      if_data_q  <= '0;
      d_rdata_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      readm_q    <= readm_d;
      writem_q   <= writem_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      fetch_q    <= fetch_d;
      if_ready_q <= if_ready_d;
      d_ready_q  <= d_ready_d;
      err_q      <= err_d;
      if_data_q  <= if_data_d;
      d_rdata_q  <= d_rdata_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  assign mem.readM   = readm_q;
  assign mem.writeM  = writem_q;
  assign mem.address = addr_q;
  assign data        = writem_q ? wdata_q : 'z;
  assign if_ready    = if_ready_q;
  assign d_ready     = d_ready_q;
  assign if_data     = if_data_q;
  assign d_rdata     = d_rdata_q;
  assign busy        = busy_q;
  assign err         = err_q;
endmodule
